// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: frames one SD SPI-mode command (index, argument, CRC7)
// into CS/byte operations for the SPI engine, then polls for the R1 byte.
//
// Ports:
//   clk_i, rst_i           system clock, synchronous active-high reset
//   start_i                one-cycle command request (ignored while busy_o)
//   cmd_idx_i/arg_i/crc_i  command fields, latched on accepted start
//   keep_cs_i              1 = leave CS asserted after R1
//   busy_o, done_o         busy window and one-cycle completion pulse
//   r1_o, err_noresp_o,    result byte and error flags, valid with done_o
//   err_timeout_o
//   spi_enable_o, spi_cmd_index_o, spi_data_out_o   to SPI engine
//   spi_data_read_i, spi_cmd_done_i                 from SPI engine
module sd_cmd_sequencer #(
    parameter int unsigned GAP_CYCLES  = 400,
    parameter int unsigned R1_POLL_MAX = 8,
    parameter int unsigned OP_TIMEOUT  = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_idx_i,
    input  logic [31:0] cmd_arg_i,
    input  logic [6:0]  cmd_crc_i,
    input  logic        keep_cs_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  r1_o,
    output logic        err_noresp_o,
    output logic        err_timeout_o,
    output logic        spi_enable_o,
    output logic [1:0]  spi_cmd_index_o,
    output logic [7:0]  spi_data_out_o,
    input  logic [7:0]  spi_data_read_i,
    input  logic        spi_cmd_done_i
);

    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned POLL_W = $clog2(R1_POLL_MAX + 1);
    localparam int unsigned WD_W   = 16;

    localparam logic [1:0] IDX_CS_ON  = 2'd0;
    localparam logic [1:0] IDX_CS_OFF = 2'd1;
    localparam logic [1:0] IDX_XFER   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CS_ON, ST_TX, ST_POLL, ST_CS_OFF, ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        OP_REQ, OP_WAIT, OP_GAP
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [2:0]          byte_q, byte_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                sync1_q, sync2_q;
    logic [5:0]          idx_q, idx_d;
    logic [31:0]         arg_q, arg_d;
    logic [6:0]          crc_q, crc_d;
    logic                keep_q, keep_d;
    logic [7:0]          rx_q, rx_d;
    logic                abort_q, abort_d;
    logic [7:0]          res_r1_q, res_r1_d;
    logic                res_nr_q, res_nr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          r1_q, r1_d;
    logic                nr_q, nr_d;
    logic                to_q, to_d;
    logic                en_q, en_d;
    logic [1:0]          cidx_q, cidx_d;
    logic [7:0]          dout_q, dout_d;

    logic                done_sync;
    logic                wd_expired;
    logic                launch;
    logic [1:0]          launch_idx;
    logic [7:0]          launch_data;
    logic                go_fin;

    assign done_sync  = sync2_q;
    assign wd_expired = (wd_q == WD_W'(OP_TIMEOUT - 1));

    // Byte n of the 6-byte command frame
    function automatic logic [7:0] frame_byte(input logic [2:0]  n,
                                              input logic [5:0]  idx,
                                              input logic [31:0] arg,
                                              input logic [6:0]  crc);
        logic [7:0] b;
        case (n)
            3'd0:    b = {2'b01, idx};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = {crc, 1'b1};
        endcase
        return b;
    endfunction

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_GAP;
            byte_q   <= '0;
            poll_q   <= '0;
            gap_q    <= '0;
            wd_q     <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            idx_q    <= '0;
            arg_q    <= '0;
            crc_q    <= '0;
            keep_q   <= 1'b0;
            rx_q     <= 8'hFF;
            abort_q  <= 1'b0;
            res_r1_q <= 8'hFF;
            res_nr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            r1_q     <= 8'hFF;
            nr_q     <= 1'b0;
            to_q     <= 1'b0;
            en_q     <= 1'b0;
            cidx_q   <= IDX_CS_ON;
            dout_q   <= 8'hFF;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            byte_q   <= byte_d;
            poll_q   <= poll_d;
            gap_q    <= gap_d;
            wd_q     <= wd_d;
            sync1_q  <= spi_cmd_done_i;
            sync2_q  <= sync1_q;
            idx_q    <= idx_d;
            arg_q    <= arg_d;
            crc_q    <= crc_d;
            keep_q   <= keep_d;
            rx_q     <= rx_d;
            abort_q  <= abort_d;
            res_r1_q <= res_r1_d;
            res_nr_q <= res_nr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            r1_q     <= r1_d;
            nr_q     <= nr_d;
            to_q     <= to_d;
            en_q     <= en_d;
            cidx_q   <= cidx_d;
            dout_q   <= dout_d;
        end
    end

    // Next-state: command phase sequencing plus per-op REQ/WAIT/GAP handshake
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        byte_d      = byte_q;
        poll_d      = poll_q;
        gap_d       = gap_q;
        wd_d        = wd_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        crc_d       = crc_q;
        keep_d      = keep_q;
        rx_d        = rx_q;
        abort_d     = abort_q;
        res_r1_d    = res_r1_q;
        res_nr_d    = res_nr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        r1_d        = r1_q;
        nr_d        = nr_q;
        to_d        = to_q;
        en_d        = en_q;
        cidx_d      = cidx_q;
        dout_d      = dout_q;
        launch      = 1'b0;
        launch_idx  = IDX_XFER;
        launch_data = 8'hFF;
        go_fin      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d      = cmd_idx_i;
                    arg_d      = cmd_arg_i;
                    crc_d      = cmd_crc_i;
                    keep_d     = keep_cs_i;
                    busy_d     = 1'b1;
                    nr_d       = 1'b0;
                    to_d       = 1'b0;
                    abort_d    = 1'b0;
                    res_r1_d   = 8'hFF;
                    res_nr_d   = 1'b0;
                    byte_d     = 3'd0;
                    poll_d     = '0;
                    state_d    = ST_CS_ON;
                    launch     = 1'b1;
                    launch_idx = IDX_CS_ON;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                case (op_q)
                    OP_REQ: begin
                        // cmd_done may still be high from the last op; wait for the engine to drop it
                        wd_d = wd_q + WD_W'(1);
                        if (!done_sync) begin
                            op_d = OP_WAIT;
                        end else if (wd_expired) begin
                            en_d     = 1'b0;
                            abort_d  = 1'b1;
                            res_r1_d = 8'hFF;
                            res_nr_d = 1'b0;
                            op_d     = OP_GAP;
                            gap_d    = '0;
                        end
                    end
                    OP_WAIT: begin
                        wd_d = wd_q + WD_W'(1);
                        if (done_sync) begin
                            rx_d  = spi_data_read_i;
                            en_d  = 1'b0;
                            op_d  = OP_GAP;
                            gap_d = '0;
                            if (state_q == ST_POLL && poll_q < POLL_W'(R1_POLL_MAX)) begin
                                poll_d = poll_q + POLL_W'(1);
                            end
                        end else if (wd_expired) begin
                            en_d     = 1'b0;
                            abort_d  = 1'b1;
                            res_r1_d = 8'hFF;
                            res_nr_d = 1'b0;
                            op_d     = OP_GAP;
                            gap_d    = '0;
                        end
                    end
                    default: begin
                        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                            gap_d = '0;
                            if (abort_q) begin
                                go_fin = 1'b1;
                            end else begin
                                case (state_q)
                                    ST_CS_ON: begin
                                        state_d     = ST_TX;
                                        byte_d      = 3'd0;
                                        launch      = 1'b1;
                                        launch_data = frame_byte(3'd0, idx_q, arg_q, crc_q);
                                    end
                                    ST_TX: begin
                                        launch = 1'b1;
                                        if (byte_q == 3'd5) begin
                                            state_d = ST_POLL;
                                            poll_d  = '0;
                                        end else begin
                                            byte_d      = byte_q + 3'd1;
                                            launch_data = frame_byte(byte_q + 3'd1, idx_q, arg_q, crc_q);
                                        end
                                    end
                                    ST_POLL: begin
                                        if (!rx_q[7] || poll_q == POLL_W'(R1_POLL_MAX)) begin
                                            // No response reports as FF, not the last idle byte
                                            res_r1_d = rx_q[7] ? 8'hFF : rx_q;
                                            res_nr_d = rx_q[7];
                                            if (keep_q) begin
                                                go_fin = 1'b1;
                                            end else begin
                                                state_d    = ST_CS_OFF;
                                                launch     = 1'b1;
                                                launch_idx = IDX_CS_OFF;
                                            end
                                        end else begin
                                            launch = 1'b1;
                                        end
                                    end
                                    default: go_fin = 1'b1;
                                endcase
                            end
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                endcase
            end
        endcase

        // Start a new SPI op; index/data held constant until the next launch
        if (launch) begin
            op_d   = OP_REQ;
            wd_d   = '0;
            en_d   = 1'b1;
            cidx_d = launch_idx;
            dout_d = launch_data;
        end

        // Results land on the same edge that raises done
        if (go_fin) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            r1_d    = res_r1_d;
            nr_d    = res_nr_d;
            to_d    = abort_q;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign r1_o            = r1_q;
    assign err_noresp_o    = nr_q;
    assign err_timeout_o   = to_q;
    assign spi_enable_o    = en_q;
    assign spi_cmd_index_o = cidx_q;
    assign spi_data_out_o  = dout_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Testbench for sd_cmd_sequencer: behavioural SPI engine, table-driven
// directed commands, randomized commands against a frame-level reference.
module tb_sd_cmd_sequencer;

    localparam int GAP  = 16;
    localparam int PMAX = 8;
    localparam int TMO  = 300;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        keep;
        logic [63:0] resp;   // poll response k in resp[8k +: 8]
        logic [7:0]  hang;   // op number that never completes, FF = none
        logic [7:0]  e_r1;
        logic        e_nr;
        logic        e_to;
        logic [4:0]  e_nops;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  cmd_crc = '0;
    logic        keep_cs = 1'b0;
    logic        busy, done, err_noresp, err_timeout, spi_enable;
    logic [7:0]  r1, spi_data_out;
    logic [1:0]  spi_cmd_index;
    logic [7:0]  spi_data_read = 8'hFF;
    logic        spi_cmd_done = 1'b0;

    int total = 0;
    int bad   = 0;

    sd_cmd_sequencer #(.GAP_CYCLES(GAP), .R1_POLL_MAX(PMAX), .OP_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .cmd_idx_i(cmd_idx), .cmd_arg_i(cmd_arg), .cmd_crc_i(cmd_crc), .keep_cs_i(keep_cs),
        .busy_o(busy), .done_o(done), .r1_o(r1),
        .err_noresp_o(err_noresp), .err_timeout_o(err_timeout),
        .spi_enable_o(spi_enable), .spi_cmd_index_o(spi_cmd_index), .spi_data_out_o(spi_data_out),
        .spi_data_read_i(spi_data_read), .spi_cmd_done_i(spi_cmd_done)
    );

    always #5 clk = ~clk;

    // SPI engine model and op monitor, all on the falling edge
    int          m_st = 0, m_cnt = 0, m_n = 0;
    bit          m_hang = 0;
    logic        en_prev = 1'b0;
    int          low_run = 0;
    logic [1:0]  cur_idx = '0;
    logic [7:0]  cur_data = '0;
    bit          first_op = 1;
    int          gap_bad = 0, gap_chk = 0, stab_bad = 0;
    logic [63:0] cur_resp = '1;
    int          hang_op = 255;
    logic [9:0]  ops_q[$];

    always @(negedge clk) begin
        if (spi_enable === 1'b1 && en_prev !== 1'b1) begin
            ops_q.push_back({spi_cmd_index, spi_data_out});
            cur_idx  = spi_cmd_index;
            cur_data = spi_data_out;
            if (!first_op) begin
                gap_chk++;
                if (low_run != GAP) gap_bad++;
            end
            first_op = 0;
        end else if (spi_enable === 1'b1) begin
            if (spi_cmd_index !== cur_idx || spi_data_out !== cur_data) stab_bad++;
        end
        low_run = (spi_enable === 1'b1) ? 0 : low_run + 1;
        en_prev = spi_enable;
        if (spi_enable !== 1'b1) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: begin
                    m_n    = ops_q.size() - 1;
                    m_hang = (m_n == hang_op);
                    m_cnt  = $urandom_range(3, 0);
                    m_st   = 1;
                end
                1: begin
                    if (m_cnt == 0) begin
                        spi_cmd_done = 1'b0;
                        m_cnt = $urandom_range(6, 2);
                        m_st  = 2;
                    end else m_cnt--;
                end
                2: begin
                    if (!m_hang) begin
                        if (m_cnt == 0) begin
                            if (m_n >= 7 && m_n < 7 + PMAX) spi_data_read = cur_resp[8*(m_n-7) +: 8];
                            else spi_data_read = 8'($urandom);
                            spi_cmd_done = 1'b1;
                            m_st = 3;
                        end else m_cnt--;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: expected op list and result from the command rules
    logic [9:0] exp_q[$];
    logic [7:0] exp_r1;
    logic       exp_nr, exp_to;

    task automatic build_expect(input vec_t v);
        logic [7:0] fr [6];
        logic [7:0] b;
        fr[0] = {2'b01, v.idx};
        fr[1] = v.arg[31:24];
        fr[2] = v.arg[23:16];
        fr[3] = v.arg[15:8];
        fr[4] = v.arg[7:0];
        fr[5] = {v.crc, 1'b1};
        exp_q.delete();
        exp_q.push_back({2'd0, 8'hFF});
        for (int i = 0; i < 6; i++) exp_q.push_back({2'd2, fr[i]});
        exp_r1 = 8'hFF;
        exp_nr = 1'b1;
        for (int k = 0; k < PMAX; k++) begin
            exp_q.push_back({2'd2, 8'hFF});
            b = v.resp[8*k +: 8];
            if (!b[7]) begin
                exp_r1 = b;
                exp_nr = 1'b0;
                break;
            end
        end
        if (!v.keep) exp_q.push_back({2'd1, 8'hFF});
        exp_to = 1'b0;
        if (int'(v.hang) < exp_q.size()) begin
            while (exp_q.size() > int'(v.hang) + 1) void'(exp_q.pop_back());
            exp_to = 1'b1;
        end
    endtask

    task automatic launch(input vec_t v);
        build_expect(v);
        cur_resp = v.resp;
        hang_op  = int'(v.hang);
        ops_q.delete();
        first_op = 1;
        cmd_idx  = v.idx;
        cmd_arg  = v.arg;
        cmd_crc  = v.crc;
        keep_cs  = v.keep;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("enable_after_start", spi_enable, 1);
    endtask

    task automatic check_ops(input string tag);
        chk({tag, "_nops"}, ops_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ops_q.size(); i++) begin
            chk($sformatf("%s_op%0d_idx", tag, i), ops_q[i][9:8], exp_q[i][9:8]);
            if (exp_q[i][9:8] == 2'd2) chk($sformatf("%s_op%0d_data", tag, i), ops_q[i][7:0], exp_q[i][7:0]);
        end
    endtask

    task automatic run_cmd(input vec_t v, input string tag, input bit tab, input bit fin_start);
        int n;
        launch(v);
        n = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done, 1);
        if (done === 1'b1) begin
            chk({tag, "_busy_at_done"}, busy, 1);
            chk({tag, "_to"}, err_timeout, exp_to);
            if (!exp_to) begin
                chk({tag, "_r1"}, r1, exp_r1);
                chk({tag, "_noresp"}, err_noresp, exp_nr);
            end
            if (tab) begin
                chk({tag, "_tab_to"}, err_timeout, v.e_to);
                chk({tag, "_tab_nops"}, ops_q.size(), v.e_nops);
                if (!v.e_to) begin
                    chk({tag, "_tab_r1"}, r1, v.e_r1);
                    chk({tag, "_tab_nr"}, err_noresp, v.e_nr);
                end
            end
            check_ops(tag);
            if (fin_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_busy_clear"}, busy, 0);
            chk({tag, "_enable_idle"}, spi_enable, 0);
            repeat (3) @(negedge clk);
            chk({tag, "_still_idle"}, busy, 0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_r1"}, r1, 8'hFF);
        chk({tag, "_noresp"}, err_noresp, 0);
        chk({tag, "_timeout"}, err_timeout, 0);
        chk({tag, "_enable"}, spi_enable, 0);
        chk({tag, "_index"}, spi_cmd_index, 0);
        chk({tag, "_data"}, spi_data_out, 8'hFF);
    endtask

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                                input logic keep, input logic [63:0] resp, input logic [7:0] hang,
                                input logic [7:0] e_r1, input logic e_nr, input logic e_to,
                                input logic [4:0] e_nops);
        vec_t v;
        v.idx = idx; v.arg = arg; v.crc = crc; v.keep = keep; v.resp = resp; v.hang = hang;
        v.e_r1 = e_r1; v.e_nr = e_nr; v.e_to = e_to; v.e_nops = e_nops;
        return v;
    endfunction

    vec_t tab [8];

    initial begin
        vec_t v;
        int   n;
        tab[0] = mk(6'd0,  32'h0000_0000, 7'h4A, 1'b0, 64'hFFFF_FFFF_FF01_FFFF, 8'hFF, 8'h01, 1'b0, 1'b0, 5'd11);
        tab[1] = mk(6'd17, 32'h0000_1000, 7'h2A, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 8'hFF, 8'h00, 1'b0, 1'b0, 5'd8);
        tab[2] = mk(6'd8,  32'h0000_01AA, 7'h43, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 5'd16);
        tab[3] = mk(6'd1,  32'h0000_0000, 7'h7C, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2,  8'hFF, 1'b0, 1'b1, 5'd3);
        tab[4] = mk(6'd12, 32'hDEAD_BEEF, 7'h11, 1'b0, 64'h05FF_FFFF_FFFF_FFFF, 8'hFF, 8'h05, 1'b0, 1'b0, 5'd16);
        tab[5] = mk(6'd55, 32'h1234_5678, 7'h33, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 5'd15);
        tab[6] = mk(6'd41, 32'h4000_0000, 7'h3B, 1'b0, 64'hFFFF_FFFF_FFFF_FF01, 8'd0,  8'hFF, 1'b0, 1'b1, 5'd1);
        tab[7] = mk(6'd16, 32'h0000_0200, 7'h0A, 1'b0, 64'hFFFF_FFFF_FFFF_FF01, 8'd8,  8'hFF, 1'b0, 1'b1, 5'd9);

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_cmd(tab[i], $sformatf("tab%0d", i), 1'b1, (i == 0));

        // start during TX is ignored; reset during POLL returns everything to reset values
        v = tab[2];
        launch(v);
        n = 0;
        while (ops_q.size() < 3 && n < 2000) begin @(negedge clk); n++; end
        chk("rst_seq_reached_tx", ops_q.size() >= 3, 1);
        cmd_idx = 6'd63;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_tx", busy, 1);
        n = 0;
        while (ops_q.size() < 8 && n < 2000) begin @(negedge clk); n++; end
        chk("rst_seq_reached_poll", ops_q.size() >= 8, 1);
        for (int i = 0; i < 8 && i < ops_q.size(); i++)
            chk($sformatf("ignored_start_op%0d", i), ops_q[i], (exp_q[i][9:8] == 2'd2) ? exp_q[i] : {exp_q[i][9:8], ops_q[i][7:0]});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midop_reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_vals("after_reset");
        run_cmd(tab[0], "fresh_cmd0", 1'b1, 1'b0);

        // randomized commands against the reference
        for (int t = 0; t < 40; t++) begin
            int mode;
            logic [7:0] b;
            v = '0;
            v.idx  = 6'($urandom);
            v.arg  = $urandom;
            v.crc  = 7'($urandom);
            v.keep = 1'($urandom);
            mode   = $urandom_range(3, 0);
            for (int k = 0; k < 8; k++) begin
                b = 8'($urandom);
                b[7] = (mode == 0) ? 1'b1 : ($urandom_range(2, 0) != 0);
                v.resp[8*k +: 8] = b;
            end
            v.hang = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(15, 0)) : 8'hFF;
            run_cmd(v, $sformatf("rnd%0d", t), 1'b0, 1'b0);
        end

        chk("gap_exact", gap_bad, 0);
        chk("gap_checked", gap_chk > 100, 1);
        chk("op_stable", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Frames one SD-card SPI-mode command (CMD index, 32-bit argument, CRC7) into the byte-level operations of the SPI engine, then polls for the R1 response. It sits directly upstream of `spi_module`. It drives that module's `enable`, `cmd_index` and `data_out` inputs, and consumes its `data_read` and `cmd_done` outputs. Host logic (the init/read FSM) issues one command per `start` pulse and receives R1 plus error flags.

## Interface
- `GAP_CYCLES`, default 400: clk cycles `spi_enable` is held low between ops. Must be ≥ 2 SPI slow-clock periods (2×160 clk at low speed).
- `R1_POLL_MAX`, default 8: maximum 0xFF poll bytes sent while waiting for R1.
- `OP_TIMEOUT`, default 65535: clk-cycle watchdog per SPI op, measured from `spi_enable` rising to completion.
- `clk` in 1: system clock, same clock that feeds the SPI engine.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request. Ignored while `busy`=1.
- `cmd_idx` in 6: SD command index. Latched on accepted `start`.
- `cmd_arg` in 32: command argument. Latched on accepted `start`.
- `cmd_crc` in 7: CRC7. Latched on accepted `start`.
- `keep_cs` in 1: 1 = leave CS asserted after R1 (data phase follows). Latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle completion pulse.
- `r1` out 8: R1 byte. Valid with `done`, held until next `start`.
- `err_noresp` out 1: no R1 within `R1_POLL_MAX`. Valid with `done`.
- `err_timeout` out 1: SPI op watchdog expired. Valid with `done`.
- `spi_enable` out 1: to SPI engine `enable`.
- `spi_cmd_index` out 2: 0 = CS assert, 1 = CS deassert, 2 = byte transfer.
- `spi_data_out` out 8: byte to transmit.
- `spi_data_read` in 8: received byte from SPI engine.
- `spi_cmd_done` in 1: op-complete from SPI engine. Synchronised internally with 2 flops.

## Operation
- Reset values: `busy`=0, `done`=0, `r1`=8'hFF, `err_noresp`=0, `err_timeout`=0, `spi_enable`=0, `spi_cmd_index`=0, `spi_data_out`=8'hFF.
- Main FSM: IDLE → CS_ON → TX (6 bytes) → POLL → [CS_OFF if !keep_cs] → FIN → IDLE.
- CS_ON: issues one op with index 0.
- TX bytes, in order:
  - {2'b01, cmd_idx}
  - cmd_arg[31:24], [23:16], [15:8], [7:0]
  - {cmd_crc, 1'b1}
- POLL: transfers 8'hFF.
  - Exit on the first received byte with bit7=0; that byte is latched into `r1`.
  - After `R1_POLL_MAX` bytes with bit7=1: `err_noresp`=1 and `r1`=8'hFF.
  - With `keep_cs`=0, CS_OFF is still issued on either exit.
- FIN: `done`=1 for one cycle. Next cycle `busy`=0 and the FSM is in IDLE.
- Op sub-handshake, used for every SPI op:
  - OP_REQ: drive index/data, `spi_enable`=1, wait for synced `spi_cmd_done`=0. This wait is required because `cmd_done` stays high from the previous op until the engine accepts the new one.
  - OP_WAIT: wait for synced `spi_cmd_done`=1, then capture `spi_data_read`.
  - OP_GAP: `spi_enable`=0 for exactly `GAP_CYCLES` clk, then advance.
- `spi_cmd_index` and `spi_data_out` are stable for the whole interval where `spi_enable`=1.
- Counters:
  - byte counter 3 bits, 0..5
  - poll counter sized to `R1_POLL_MAX`, saturating
  - watchdog 16 bits
  - gap counter sized to `GAP_CYCLES`
- Watchdog expiry in OP_REQ/OP_WAIT: `spi_enable`=0, `err_timeout`=1, skip CS_OFF, then one OP_GAP, then FIN.

## Timing
- `start` accepted in cycle N: `busy`=1 at N+1. `spi_enable` rises at N+1 (CS_ON).
- `spi_cmd_done` synced high seen at cycle M: `spi_enable`=0 at M+1. The next op's `spi_enable` rises at M+1+`GAP_CYCLES`.
- Error flags and `r1` update on the same edge that raises `done`. Error flags clear on the next accepted `start`.
- `start` while `busy`: no effect. `start` in the FIN cycle: ignored.
- `rst` mid-op: all outputs return to reset values on the next edge, including `spi_enable`=0 immediately. The SPI engine returns to its idle state after seeing enable low. CS may remain low; the host issues a new command, whose CS_ON is harmless.

## Test plan
- CMD0, arg 0, crc 7'h4A, keep_cs=0; SPI model returns FF,FF,01 in POLL → MOSI bytes 40 00 00 00 00 95 FF FF FF, CS op sequence 0,2×9,1, `r1`=01, no errors, `done` one cycle.
- CMD17, arg 32'h00001000, keep_cs=1; R1=00 on the first poll → bytes 51 00 00 10 00 xx FF, no CS_OFF op, `r1`=00.
- Model always returns FF → exactly 8 poll bytes, `err_noresp`=1, `r1`=FF, CS_OFF issued.
- Model never asserts `cmd_done` on the 3rd op → after 65535 cycles `spi_enable`=0, `err_timeout`=1, `done` pulse, return to IDLE.
- `start` pulsed during TX, then `rst` asserted during POLL → second start ignored; after reset all outputs at reset values; a fresh CMD0 completes normally.
- Check every op: `spi_enable` low gap ≥ `GAP_CYCLES`, and index/data never change while enable=1.
